// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// the NOP used by the flush paths, and the bundled pipeline-control word.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Instruction word loaded into IF/ID or ID/EX when a flush pin is raised.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // One bit per pipeline-register control pin, ordered PC first, WB last.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_we;
    } ctl_t;

    // Everything advances, nothing flushed.
    localparam ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    // Whole pipe frozen (cache miss, halt).
    localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Taken branch: everything advances, the two wrong-path slots become NOPs.
    localparam ctl_t CTL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Front end holds, a bubble is injected into ID/EX, back end drains.
    localparam ctl_t CTL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // Held in reset: nothing written, both flush pins asserted.
    localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Source operand in ID collides with the EX destination (full-width compare,
    // r0 is an ordinary register on this core).
    function automatic logic reg_match(input logic [2:0] src,
                                       input logic       used,
                                       input logic [2:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage 16-bit core.
// Drives the PC / pipeline-register enables and flushes for load-use stalls,
// taken-branch flushes, I/D cache-miss freezes and HALT, and counts stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic             ex_memread,
    input  logic [2:0]       ex_wreg,
    input  logic             ex_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             wb_halt,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state;
    state_t state_nxt;
    state_t run_nxt;
    ctl_t   run_ctl;
    ctl_t   ctl;
    logic   load_use;
    logic   halted_c;
    logic   stall_inc;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = ex_memread &&
                   (reg_match(id_rs, id_rs_used, ex_wreg) ||
                    reg_match(id_rt, id_rt_used, ex_wreg));
    end

    // Priority decode used in RUN and on the DWAIT release cycle.
    always_comb begin
        run_ctl = CTL_RUN;
        run_nxt = ST_RUN;
        if (wb_halt) begin
            run_ctl = CTL_FREEZE;
            run_nxt = ST_HALT;
        end else if (dmem_stall) begin
            run_ctl = CTL_FREEZE;
            run_nxt = ST_DWAIT;
        end else if (ex_br_taken) begin
            // Overrides load-use and imem stall: the ID/IF contents are wrong-path.
            run_ctl = CTL_FLUSH;
        end else if (load_use) begin
            run_ctl = CTL_BUBBLE;
        end else if (imem_stall) begin
            run_ctl = CTL_BUBBLE;
        end
    end

    // FSM next state and Mealy outputs.
    always_comb begin
        ctl       = CTL_FREEZE;
        state_nxt = state;
        halted_c  = 1'b0;
        if (rst) begin
            ctl       = CTL_RESET;
            state_nxt = ST_RUN;
        end else begin
            unique case (state)
                ST_RUN: begin
                    ctl       = run_ctl;
                    state_nxt = run_nxt;
                end
                ST_DWAIT: begin
                    // Frozen EX/ID still hold any branch or load-use, so the
                    // release cycle simply re-runs the RUN decode.
                    if (dmem_stall && !wb_halt) begin
                        ctl       = CTL_FREEZE;
                        state_nxt = ST_DWAIT;
                    end else begin
                        ctl       = run_ctl;
                        state_nxt = run_nxt;
                    end
                end
                ST_HALT: begin
                    ctl       = CTL_FREEZE;
                    state_nxt = ST_HALT;
                    halted_c  = 1'b1;
                end
                default: begin
                    ctl       = CTL_FREEZE;
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A cycle counts as a stall when the PC holds outside HALT; the HALT-entry
    // cycle is still in RUN/DWAIT and therefore counts.
    always_comb begin
        stall_inc = !rst && !ctl.pc_we && (state != ST_HALT);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    // Unpack the control word onto the pipeline pins.
    always_comb begin
        pc_we       = ctl.pc_we;
        if_id_we    = ctl.if_id_we;
        if_id_flush = ctl.if_id_flush;
        id_ex_we    = ctl.id_ex_we;
        id_ex_flush = ctl.id_ex_flush;
        ex_mem_we   = ctl.ex_mem_we;
        mem_wb_we   = ctl.mem_wb_we;
        halted      = halted_c;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-width instance and a CNT_W=4
// instance share one stimulus stream; control pins and counters are checked
// against hand-computed patterns every cycle.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] id_rs;
    logic       id_rs_used;
    logic [2:0] id_rt;
    logic       id_rt_used;
    logic       ex_memread;
    logic [2:0] ex_wreg;
    logic       ex_br_taken;
    logic       imem_stall;
    logic       dmem_stall;
    logic       wb_halt;

    logic        pc_we_b, if_id_we_b, if_id_flush_b, id_ex_we_b, id_ex_flush_b;
    logic        ex_mem_we_b, mem_wb_we_b, halted_b;
    logic [15:0] cnt_b;
    logic        pc_we_s, if_id_we_s, if_id_flush_s, id_ex_we_s, id_ex_flush_s;
    logic        ex_mem_we_s, mem_wb_we_s, halted_s;
    logic [3:0]  cnt_s;

    logic [7:0] obs_b;
    logic [7:0] obs_s;

    int vectors;
    int miscompares;
    int exp_cnt;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, halted}
    localparam logic [7:0] P_RUN = 8'b1101_0110;
    localparam logic [7:0] P_FRZ = 8'b0000_0000;
    localparam logic [7:0] P_BR  = 8'b1111_1110;
    localparam logic [7:0] P_BUB = 8'b0001_1110;
    localparam logic [7:0] P_RST = 8'b0010_1000;
    localparam logic [7:0] P_HLT = 8'b0000_0001;

    hazard_ctrl u_big (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rt       (id_rt),
        .id_rt_used  (id_rt_used),
        .ex_memread  (ex_memread),
        .ex_wreg     (ex_wreg),
        .ex_br_taken (ex_br_taken),
        .imem_stall  (imem_stall),
        .dmem_stall  (dmem_stall),
        .wb_halt     (wb_halt),
        .pc_we       (pc_we_b),
        .if_id_we    (if_id_we_b),
        .if_id_flush (if_id_flush_b),
        .id_ex_we    (id_ex_we_b),
        .id_ex_flush (id_ex_flush_b),
        .ex_mem_we   (ex_mem_we_b),
        .mem_wb_we   (mem_wb_we_b),
        .halted      (halted_b),
        .stall_cnt   (cnt_b)
    );

    hazard_ctrl #(.CNT_W(4)) u_sml (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rt       (id_rt),
        .id_rt_used  (id_rt_used),
        .ex_memread  (ex_memread),
        .ex_wreg     (ex_wreg),
        .ex_br_taken (ex_br_taken),
        .imem_stall  (imem_stall),
        .dmem_stall  (dmem_stall),
        .wb_halt     (wb_halt),
        .pc_we       (pc_we_s),
        .if_id_we    (if_id_we_s),
        .if_id_flush (if_id_flush_s),
        .id_ex_we    (id_ex_we_s),
        .id_ex_flush (id_ex_flush_s),
        .ex_mem_we   (ex_mem_we_s),
        .mem_wb_we   (mem_wb_we_s),
        .halted      (halted_s),
        .stall_cnt   (cnt_s)
    );

    assign obs_b = {pc_we_b, if_id_we_b, if_id_flush_b, id_ex_we_b,
                    id_ex_flush_b, ex_mem_we_b, mem_wb_we_b, halted_b};
    assign obs_s = {pc_we_s, if_id_we_s, if_id_flush_s, id_ex_we_s,
                    id_ex_flush_s, ex_mem_we_s, mem_wb_we_s, halted_s};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_in();
        id_rs       = 3'd0;
        id_rs_used  = 1'b0;
        id_rt       = 3'd0;
        id_rt_used  = 1'b0;
        ex_memread  = 1'b0;
        ex_wreg     = 3'd0;
        ex_br_taken = 1'b0;
        imem_stall  = 1'b0;
        dmem_stall  = 1'b0;
        wb_halt     = 1'b0;
    endtask

    task automatic set_ld(input logic [2:0] wreg, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu);
        ex_memread = 1'b1;
        ex_wreg    = wreg;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
    endtask

    // Check the Mealy outputs for the current inputs, clock once, then check
    // both counters against the expected count (inc = this cycle is a stall).
    task automatic cycle(input string tag, input logic [7:0] exp_o, input bit inc);
        int exp_s;
        #1;
        vectors++;
        assert (obs_b === exp_o) else begin
            miscompares++;
            $error("FAIL %s ctl16: observed %b expected %b", tag, obs_b, exp_o);
        end
        vectors++;
        assert (obs_s === exp_o) else begin
            miscompares++;
            $error("FAIL %s ctl4: observed %b expected %b", tag, obs_s, exp_o);
        end
        @(posedge clk);
        #1;
        if (rst) exp_cnt = 0;
        else if (inc) exp_cnt++;
        exp_s = (exp_cnt > 15) ? 15 : exp_cnt;
        vectors++;
        assert (cnt_b === 16'(exp_cnt)) else begin
            miscompares++;
            $error("FAIL %s cnt16: observed %0d expected %0d", tag, cnt_b, exp_cnt);
        end
        vectors++;
        assert (cnt_s === 4'(exp_s)) else begin
            miscompares++;
            $error("FAIL %s cnt4: observed %0d expected %0d", tag, cnt_s, exp_s);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        rst         = 1'b1;
        clear_in();

        // Reset state
        cycle("reset0", P_RST, 0);
        ex_br_taken = 1'b1;
        dmem_stall  = 1'b1;
        cycle("reset1", P_RST, 0);
        rst = 1'b0;
        clear_in();
        cycle("idle", P_RUN, 0);

        // Load-use on rs: one bubble, then enables back to 1
        set_ld(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
        cycle("lu_rs", P_BUB, 1);
        clear_in();
        cycle("lu_after", P_RUN, 0);

        // Matching field but not used: no stall
        set_ld(3'd5, 3'd5, 1'b0, 3'd5, 1'b0);
        cycle("lu_neg", P_RUN, 0);
        // rt match
        set_ld(3'd5, 3'd1, 1'b1, 3'd5, 1'b1);
        cycle("lu_rt", P_BUB, 1);
        // r0 is an ordinary register
        set_ld(3'd0, 3'd0, 1'b1, 3'd2, 1'b0);
        cycle("lu_r0", P_BUB, 1);
        // Differs only in bit 2: full-width compare must miss
        set_ld(3'd4, 3'd0, 1'b1, 3'd0, 1'b1);
        cycle("lu_width", P_RUN, 0);
        // Register match without a load
        set_ld(3'd3, 3'd3, 1'b1, 3'd3, 1'b1);
        ex_memread = 1'b0;
        cycle("no_load", P_RUN, 0);

        // Taken branch overrides load-use and imem stall
        set_ld(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
        ex_br_taken = 1'b1;
        cycle("br_lu", P_BR, 0);
        clear_in();
        ex_br_taken = 1'b1;
        imem_stall  = 1'b1;
        cycle("br_imem", P_BR, 0);
        clear_in();
        imem_stall = 1'b1;
        cycle("imem", P_BUB, 1);

        // D-cache miss with a branch pending: 5 frozen cycles, flush on release
        clear_in();
        dmem_stall  = 1'b1;
        ex_br_taken = 1'b1;
        for (int i = 0; i < 5; i++) cycle("dwait_br", P_FRZ, 1);
        dmem_stall = 1'b0;
        cycle("dw_release_br", P_BR, 0);
        clear_in();
        cycle("dw_after", P_RUN, 0);

        // Load-use held through a miss is applied on release
        set_ld(3'd6, 3'd2, 1'b0, 3'd6, 1'b1);
        dmem_stall = 1'b1;
        imem_stall = 1'b1;
        cycle("dwait_lu0", P_FRZ, 1);
        cycle("dwait_lu1", P_FRZ, 1);
        dmem_stall = 1'b0;
        imem_stall = 1'b0;
        cycle("dw_release_lu", P_BUB, 1);
        clear_in();
        cycle("dw_lu_after", P_RUN, 0);

        // HALT beats dmem_stall; entry cycle counts, then nothing moves
        dmem_stall = 1'b1;
        wb_halt    = 1'b1;
        cycle("halt_entry", P_FRZ, 1);
        for (int i = 0; i < 20; i++) begin
            clear_in();
            ex_br_taken = i[0];
            imem_stall  = i[1];
            dmem_stall  = i[2];
            cycle("halted", P_HLT, 0);
        end

        // Reset out of HALT
        clear_in();
        rst = 1'b1;
        cycle("rst_halt", P_RST, 0);
        rst = 1'b0;
        cycle("post_rst", P_RUN, 0);

        // Saturation: 4-bit counter sticks at 15, 16-bit keeps counting
        imem_stall = 1'b1;
        for (int i = 0; i < 20; i++) cycle("sat", P_BUB, 1);
        clear_in();
        cycle("sat_hold", P_RUN, 0);
        rst = 1'b1;
        cycle("sat_rst", P_RST, 0);
        rst = 1'b0;
        cycle("sat_post", P_RUN, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
